// File: rtl/fifo_drain_arbiter.sv
// fifo_drain_arbiter
// Read-side controller for the two per-VC destination FIFOs. Pops words
// from D0/D1, covers the FIFOs' one-cycle read latency with a 2-entry
// output buffer, and presents a single {vc, data} stream under valid/ready.
// Optional build macro: FIFO_DRAIN_STRICT_PRIO_EN (D0 always wins when both
// FIFOs are non-empty; otherwise round-robin).

module fifo_drain_arbiter #(
    parameter int BW = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          D0_empty,
    input  logic          D1_empty,
    input  logic [BW-1:0] D0_data_out,
    input  logic [BW-1:0] D1_data_out,
    output logic          D0_rd,
    output logic          D1_rd,
    output logic [BW-1:0] out_data,
    output logic          out_vc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] D0_count,
    output logic [CW-1:0] D1_count
);

    logic [1:0]  occ;
    logic [1:0]  buf_cnt;
    logic        inflight_valid;
    logic        inflight_vc;
    logic [BW:0] buf_mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic        pop;
    logic        any_avail;
    logic        room;
    logic        issue;
    logic        grant_vc;
`ifndef FIFO_DRAIN_STRICT_PRIO_EN
    logic        last_grant;
`endif

    assign out_valid = (buf_cnt != 2'd0);
    assign out_vc    = buf_mem[rd_ptr][BW];
    assign out_data  = buf_mem[rd_ptr][BW-1:0];
    assign pop       = out_valid & out_ready;
    assign any_avail = ~D0_empty | ~D1_empty;
    // occ already includes the entry being popped, so freeing it this cycle makes room now
    assign room      = ((occ - {1'b0, pop}) < 2'd2);
    assign issue     = ~reset & enable & any_avail & room;
    assign D0_rd     = issue & ~grant_vc;
    assign D1_rd     = issue & grant_vc;

    // Pick which FIFO gets the read this cycle from the live empty flags
    always_comb begin
        grant_vc = 1'b0;
        if (!D0_empty && !D1_empty) begin
`ifdef FIFO_DRAIN_STRICT_PRIO_EN
            grant_vc = 1'b0;
`else
            grant_vc = ~last_grant;
`endif
        end else if (D0_empty) begin
            grant_vc = 1'b1;
        end
    end

`ifndef FIFO_DRAIN_STRICT_PRIO_EN
    // Remember the last VC actually served so the other one wins a tie next time
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (issue) begin
            last_grant <= grant_vc;
        end
    end
`endif

    // Track the read in flight and capture its data into the output buffer a cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            occ            <= 2'd0;
            buf_cnt        <= 2'd0;
            inflight_valid <= 1'b0;
            inflight_vc    <= 1'b0;
            wr_ptr         <= 1'b0;
            rd_ptr         <= 1'b0;
            buf_mem[0]     <= '0;
            buf_mem[1]     <= '0;
        end else begin
            occ            <= occ + {1'b0, issue} - {1'b0, pop};
            buf_cnt        <= buf_cnt + {1'b0, inflight_valid} - {1'b0, pop};
            inflight_valid <= issue;
            inflight_vc    <= grant_vc;
            if (inflight_valid) begin
                buf_mem[wr_ptr] <= {inflight_vc, inflight_vc ? D1_data_out : D0_data_out};
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    // Count words handed to the consumer, per source VC, wrapping naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            D0_count <= '0;
            D1_count <= '0;
        end else if (pop) begin
            if (out_vc) begin
                D1_count <= D1_count + 1'b1;
            end else begin
                D0_count <= D0_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// tb_fifo_drain_arbiter
// Drives fifo_drain_arbiter from two queue-based FIFO models and checks
// every cycle against a transaction-level reference: a list of words in
// flight, each tagged with the cycle it becomes visible at the output.
// Honors FIFO_DRAIN_STRICT_PRIO_EN for the arbitration rule.

module tb_fifo_drain_arbiter;

    localparam int BW = 4;
    localparam int CW = 3;

    typedef struct {
        logic          vc;
        logic [BW-1:0] data;
        int            avail;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          D0_empty;
    logic          D1_empty;
    logic [BW-1:0] D0_data_out;
    logic [BW-1:0] D1_data_out;
    logic          D0_rd;
    logic          D1_rd;
    logic [BW-1:0] out_data;
    logic          out_vc;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] D0_count;
    logic [CW-1:0] D1_count;

    logic [BW-1:0] q0[$];
    logic [BW-1:0] q1[$];
    ent_t          pend[$];
    logic [CW-1:0] m_cnt0;
    logic [CW-1:0] m_cnt1;
    logic          m_last;
    int            cyc;
    int            compared;
    int            mismatched;

    fifo_drain_arbiter #(.BW(BW), .CW(CW)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .D0_empty(D0_empty),
        .D1_empty(D1_empty),
        .D0_data_out(D0_data_out),
        .D1_data_out(D1_data_out),
        .D0_rd(D0_rd),
        .D1_rd(D1_rd),
        .out_data(out_data),
        .out_vc(out_vc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .D0_count(D0_count),
        .D1_count(D1_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        pend.delete();
        m_cnt0 = '0;
        m_cnt1 = '0;
        m_last = 1'b1;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model
    task automatic step(input logic en, input logic rdy, input logic rst);
        logic e_valid;
        logic e_pop;
        logic e_issue;
        logic e_vc;
        logic [BW-1:0] w;
        ent_t e;
        @(negedge clk);
        enable    = en;
        out_ready = rdy;
        reset     = rst;
        D0_empty  = (q0.size() == 0);
        D1_empty  = (q1.size() == 0);
        #1;
        e_valid = 1'b0;
        if (pend.size() > 0) e_valid = (pend[0].avail <= cyc);
        e_pop   = e_valid && rdy;
        e_issue = !rst && en && (q0.size() > 0 || q1.size() > 0) &&
                  ((pend.size() - int'(e_pop)) < 2);
        if (q0.size() > 0 && q1.size() > 0) begin
`ifdef FIFO_DRAIN_STRICT_PRIO_EN
            e_vc = 1'b0;
`else
            e_vc = ~m_last;
`endif
        end else begin
            e_vc = (q0.size() == 0);
        end
        chk("D0_rd", 32'(D0_rd), 32'(e_issue && !e_vc));
        chk("D1_rd", 32'(D1_rd), 32'(e_issue && e_vc));
        chk("out_valid", 32'(out_valid), 32'(e_valid));
        if (e_valid) begin
            chk("out_data", 32'(out_data), 32'(pend[0].data));
            chk("out_vc", 32'(out_vc), 32'(pend[0].vc));
        end
        chk("D0_count", 32'(D0_count), 32'(m_cnt0));
        chk("D1_count", 32'(D1_count), 32'(m_cnt1));
        @(posedge clk);
        #1;
        D0_data_out = BW'($urandom);
        D1_data_out = BW'($urandom);
        if (rst) begin
            model_reset();
        end else begin
            if (e_pop) begin
                if (pend[0].vc) m_cnt1 = m_cnt1 + 1'b1;
                else            m_cnt0 = m_cnt0 + 1'b1;
                void'(pend.pop_front());
            end
            if (e_issue) begin
                if (e_vc) begin
                    w = q1.pop_front();
                    D1_data_out = w;
                end else begin
                    w = q0.pop_front();
                    D0_data_out = w;
                end
                e.vc = e_vc;
                e.data = w;
                e.avail = cyc + 2;
                pend.push_back(e);
                m_last = e_vc;
            end
        end
        cyc++;
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        cyc         = 0;
        reset       = 1'b1;
        enable      = 1'b0;
        out_ready   = 1'b0;
        D0_empty    = 1'b1;
        D1_empty    = 1'b1;
        D0_data_out = '0;
        D1_data_out = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_data", 32'(out_data), 32'h0);
        chk("reset_out_vc", 32'(out_vc), 32'h0);

        // Single-FIFO drain: 3, 5, 7 from D0
        q0.push_back(4'd3); q0.push_back(4'd5); q0.push_back(4'd7);
        repeat (6) step(1'b1, 1'b1, 1'b0);
        chk("d0_count_after_3", 32'(D0_count), 32'd3);

        // Both FIFOs loaded: round-robin (or strict priority) interleave
        for (int i = 0; i < 4; i++) begin
            q0.push_back(BW'($urandom));
            q1.push_back(BW'($urandom));
        end
        repeat (12) step(1'b1, 1'b1, 1'b0);

        // Backpressure with 5 words in D1, then release
        for (int i = 0; i < 5; i++) q1.push_back(BW'(i + 9));
        repeat (6) step(1'b1, 1'b0, 1'b0);
        repeat (8) step(1'b1, 1'b1, 1'b0);

        // Enable drops right after one read is issued
        for (int i = 0; i < 3; i++) q0.push_back(BW'($urandom));
        step(1'b1, 1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b1, 1'b0);
        q0.delete();

        // Reset with words buffered and in flight
        for (int i = 0; i < 4; i++) q0.push_back(BW'($urandom));
        repeat (3) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        #1;
        chk("post_reset_valid", 32'(out_valid), 32'h0);
        chk("post_reset_cnt0", 32'(D0_count), 32'h0);
        chk("post_reset_cnt1", 32'(D1_count), 32'h0);
        repeat (2) step(1'b0, 1'b1, 1'b0);

        // Randomized traffic with occasional enable drops and resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 40) q0.push_back(BW'($urandom));
            if ($urandom_range(0, 99) < 40) q1.push_back(BW'($urandom));
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 99) < 65),
                 ($urandom_range(0, 199) == 0));
        end

        // Final drain
        repeat (10) step(1'b1, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
